// File: rtl/mem_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_port_arbiter                                                           |
// | Round-robin owner of the single memory port (fetch vs data), with watchdog |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module mem_port_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            nrst,
  input  logic            if_req,
  input  logic [AW-1:0]   if_addr,
  output logic [DW-1:0]   if_rdata,
  output logic            if_done,
  input  logic            flush,
  input  logic            mem_req,
  input  logic            mem_we,
  input  logic [DW/8-1:0] mem_be,
  input  logic [AW-1:0]   mem_addr,
  input  logic [DW-1:0]   mem_wdata,
  output logic [DW-1:0]   mem_rdata,
  output logic            memOp_done,
  output logic            arb_eqmem,
  output logic            stall_mem,
  output logic            bus_err,
  output logic            bus_req,
  output logic            bus_we,
  output logic [DW/8-1:0] bus_be,
  output logic [AW-1:0]   bus_addr,
  output logic [DW-1:0]   bus_wdata,
  input  logic [DW-1:0]   bus_rdata,
  input  logic            bus_ack
);

  localparam int              WDW     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WDW-1:0]  WD_LAST = WDW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GNT_IF  = 2'd1,
    GNT_MEM = 2'd2
  } state_t;

  state_t         state;
  state_t         next_state;
  logic           last_mem;
  logic [WDW-1:0] wd;
  logic           drop;

  logic           if_pend;
  logic           mem_pend;
  logic           expire;
  logic           finish;
  logic           drop_now;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // A requester still high during its own done pulse has already been served.
  always_comb begin
    next_state = state;
    if_pend    = if_req && !if_done;
    mem_pend   = mem_req && !memOp_done;
    expire     = (wd == WD_LAST);
    finish     = 1'b0;
    drop_now   = drop || flush;
    case (state)
      IDLE: begin
        if (mem_pend && (!if_pend || !last_mem)) begin
          next_state = GNT_MEM;
        end else if (if_pend) begin
          next_state = GNT_IF;
        end
      end
      GNT_IF, GNT_MEM: begin
        if (bus_ack || expire) begin
          finish     = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      last_mem   <= 1'b0;
      wd         <= '0;
      drop       <= 1'b0;
      bus_req    <= 1'b0;
      bus_we     <= 1'b0;
      bus_be     <= '0;
      bus_addr   <= '0;
      bus_wdata  <= '0;
      if_rdata   <= '0;
      if_done    <= 1'b0;
      mem_rdata  <= '0;
      memOp_done <= 1'b0;
      bus_err    <= 1'b0;
    end else begin
      if_done    <= 1'b0;
      memOp_done <= 1'b0;
      bus_err    <= 1'b0;
      if (state == IDLE && next_state != IDLE) begin
        bus_req  <= 1'b1;
        wd       <= '0;
        drop     <= 1'b0;
        last_mem <= (next_state == GNT_MEM);
        if (next_state == GNT_MEM) begin
          bus_we    <= mem_we;
          bus_be    <= mem_be;
          bus_addr  <= mem_addr;
          bus_wdata <= mem_wdata;
        end else begin
          bus_we    <= 1'b0;
          bus_be    <= '1;
          bus_addr  <= if_addr;
          bus_wdata <= '0;
        end
      end else if (finish) begin
        // Ack beats a simultaneous watchdog expiry; an abort returns zero data.
        bus_req <= 1'b0;
        wd      <= '0;
        drop    <= 1'b0;
        bus_err <= !bus_ack;
        if (state == GNT_MEM) begin
          memOp_done <= 1'b1;
          mem_rdata  <= bus_ack ? bus_rdata : '0;
        end else if (!drop_now) begin
          if_done  <= 1'b1;
          if_rdata <= bus_ack ? bus_rdata : '0;
        end
      end else if (state != IDLE) begin
        wd <= wd + 1'b1;
        if (state == GNT_IF && flush) begin
          drop <= 1'b1;
        end
      end
    end
  end

  assign arb_eqmem = (state == GNT_MEM);
  // Gated by nrst so every output reads zero while reset is held.
  assign stall_mem = nrst && mem_req && (state != GNT_MEM) && !memOp_done;

endmodule
`default_nettype wire
